// File: rtl/prach_hb1_int.sv
// 2x half-band interpolator: three parallel lanes, TDM channels, 4-cycle latency.
// Define PRACH_HB1_INT_SAT_EN to saturate dout_dp2; default build wraps it.
module prach_hb1_int #(
  parameter int                 NUM_CH = 8,
  parameter logic signed [17:0] C0     = -18'sd768,
  parameter logic signed [17:0] C1     = 18'sd3520,
  parameter logic signed [17:0] C2     = -18'sd10016,
  parameter logic signed [17:0] C3     = 18'sd40032
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0][15:0] din_dq,
  input  logic             din_dv,
  input  logic [7:0]       din_chn,
  input  logic             sync_in,
  output logic [2:0][15:0] dout_dp1,
  output logic [2:0][15:0] dout_dp2,
  output logic             dout_dv,
  output logic [7:0]       dout_chn,
  output logic             sync_out,
  output logic             err_chn
);

  localparam int LANES = 3;
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CHW-1:0]               w_idx;
  logic                         w_ok;
  logic                         w_take;
  logic                         w_zero;
  logic [NUM_CH-1:0]            r_flush;
  logic [NUM_CH-1:0]            w_flush_nxt;
  logic [LANES-1:0][6:0][15:0]  r_hist [NUM_CH];
  logic [LANES-1:0][6:0][15:0]  w_hist_nxt;
  logic [LANES-1:0][7:0][15:0]  w_win;
  logic signed [17:0]           w_coef [4];

  logic                         r_s1_dv, r_s2_dv, r_s3_dv;
  logic                         r_s1_sync, r_s2_sync, r_s3_sync;
  logic [7:0]                   r_s1_chn, r_s2_chn, r_s3_chn;
  logic [LANES-1:0][7:0][15:0]  r_s1_win;
  logic signed [16:0]           r_s2_pre [LANES][4];
  logic [LANES-1:0][15:0]       r_s2_dp1, r_s3_dp1;
  logic signed [34:0]           r_s3_prod [LANES][4];
  logic [LANES-1:0][15:0]       w_dp2;
`ifdef PRACH_HB1_INT_SAT_EN
  logic signed [20:0]           w_rnd [LANES];
`endif

  function automatic logic signed [20:0] round_q16(input logic signed [34:0] p0, p1, p2, p3);
    return 21'(($signed({{2{p0[34]}}, p0}) + $signed({{2{p1[34]}}, p1}) +
                $signed({{2{p2[34]}}, p2}) + $signed({{2{p3[34]}}, p3}) + 37'sd32768) >>> 16);
  endfunction

  assign w_idx     = din_chn[CHW-1:0];
  assign w_ok      = ({24'd0, din_chn} < 32'(NUM_CH));
  assign w_take    = din_dv & w_ok & ~rst;
  assign w_zero    = sync_in | r_flush[w_idx];
  assign w_coef[0] = C0;
  assign w_coef[1] = C1;
  assign w_coef[2] = C2;
  assign w_coef[3] = C3;

  // Tap window: current sample plus stored history, or zeros after a flush.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_win[l][0] = din_dq[l];
      for (int k = 1; k < 8; k++) begin
        if (w_zero) w_win[l][k] = 16'd0;
        else        w_win[l][k] = r_hist[w_idx][l][k-1];
      end
      w_hist_nxt[l] = w_win[l][6:0];
    end
  end

  // A sync marks every channel stale; the accepted channel consumes its own mark.
  always_comb begin
    w_flush_nxt = r_flush;
    if (w_take) begin
      if (sync_in) w_flush_nxt = '1;
      else         w_flush_nxt = r_flush;
      w_flush_nxt[w_idx] = 1'b0;
    end else begin
      w_flush_nxt = r_flush;
    end
  end

  // Writing at accept time lets a same-channel follower read it next cycle.
  always_ff @(posedge clk) begin
    if (w_take) r_hist[w_idx] <= w_hist_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_flush <= '1;
    else     r_flush <= w_flush_nxt;
  end

  // Datapath stages: capture window, symmetric pre-add, multiply.
  always_ff @(posedge clk) begin
    r_s1_win <= w_win;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < 4; k++) begin
        r_s2_pre[l][k]  <= $signed({r_s1_win[l][k][15], r_s1_win[l][k]}) +
                           $signed({r_s1_win[l][7-k][15], r_s1_win[l][7-k]});
        r_s3_prod[l][k] <= $signed({{17{w_coef[k][17]}}, w_coef[k]}) *
                           $signed({{18{r_s2_pre[l][k][16]}}, r_s2_pre[l][k]});
      end
      r_s2_dp1[l] <= r_s1_win[l][4];
    end
    r_s3_dp1 <= r_s2_dp1;
  end

  // Accumulate, round to nearest (half up) and map to 16 bits.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
`ifdef PRACH_HB1_INT_SAT_EN
      w_rnd[l] = round_q16(r_s3_prod[l][0], r_s3_prod[l][1], r_s3_prod[l][2], r_s3_prod[l][3]);
      if (w_rnd[l] > 21'sd32767)       w_dp2[l] = 16'h7fff;
      else if (w_rnd[l] < -21'sd32768) w_dp2[l] = 16'h8000;
      else                             w_dp2[l] = w_rnd[l][15:0];
`else
      w_dp2[l] = 16'(round_q16(r_s3_prod[l][0], r_s3_prod[l][1], r_s3_prod[l][2], r_s3_prod[l][3]));
`endif
    end
  end

  // Control pipeline and registered outputs; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_dv   <= 1'b0;
      r_s2_dv   <= 1'b0;
      r_s3_dv   <= 1'b0;
      r_s1_sync <= 1'b0;
      r_s2_sync <= 1'b0;
      r_s3_sync <= 1'b0;
      r_s1_chn  <= 8'd0;
      r_s2_chn  <= 8'd0;
      r_s3_chn  <= 8'd0;
      dout_dv   <= 1'b0;
      dout_chn  <= 8'd0;
      sync_out  <= 1'b0;
      dout_dp1  <= '0;
      dout_dp2  <= '0;
      err_chn   <= 1'b0;
    end else begin
      r_s1_dv   <= w_take;
      r_s1_sync <= w_take & sync_in;
      r_s1_chn  <= din_chn;
      r_s2_dv   <= r_s1_dv;
      r_s2_sync <= r_s1_sync;
      r_s2_chn  <= r_s1_chn;
      r_s3_dv   <= r_s2_dv;
      r_s3_sync <= r_s2_sync;
      r_s3_chn  <= r_s2_chn;
      dout_dv   <= r_s3_dv;
      dout_chn  <= r_s3_chn;
      sync_out  <= r_s3_sync;
      dout_dp1  <= r_s3_dp1;
      dout_dp2  <= w_dp2;
      if (din_dv && !w_ok) err_chn <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prach_hb1_int.sv
// Randomised and directed bench for prach_hb1_int against an arithmetic reference model.
`timescale 1ns/1ps
module tb_prach_hb1_int;
  localparam int     NUM_CH = 8;
  localparam longint K0 = -768, K1 = 3520, K2 = -10016, K3 = 40032;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0][15:0] din_dq;
  logic             din_dv;
  logic [7:0]       din_chn;
  logic             sync_in;
  logic [2:0][15:0] dout_dp1, dout_dp2;
  logic             dout_dv;
  logic [7:0]       dout_chn;
  logic             sync_out, err_chn;

  int total = 0;
  int bad   = 0;

  // reference model state: per-channel history, flush marks, expected-output delay line
  int               mh [NUM_CH][3][7];
  bit               mflush [NUM_CH];
  bit               merr;
  bit               pdv [4];
  logic [7:0]       pchn [4];
  bit               psync [4];
  logic [2:0][15:0] pdp1 [4];
  logic [2:0][15:0] pdp2 [4];
  logic [15:0]      imp [8];

  prach_hb1_int #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
    .sync_in(sync_in), .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv),
    .dout_chn(dout_chn), .sync_out(sync_out), .err_chn(err_chn)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_dp2(input int w [8]);
    longint acc;
    longint r;
    acc = K0 * longint'(w[0] + w[7]) + K1 * longint'(w[1] + w[6]) +
          K2 * longint'(w[2] + w[5]) + K3 * longint'(w[3] + w[4]) + 64'sd32768;
    r = acc >>> 16;
`ifdef PRACH_HB1_INT_SAT_EN
    if (r > 32767) return 16'h7fff;
    if (r < -32768) return 16'h8000;
`endif
    return r[15:0];
  endfunction

  // drive one input cycle, advance the model, then step the clock
  task automatic tick(input bit dv, input int ch, input bit sy, input logic [2:0][15:0] dq);
    int w [8];
    din_dv = dv; din_chn = 8'(ch); sync_in = sy; din_dq = dq;
    for (int i = 3; i > 0; i--) begin
      pdv[i] = pdv[i-1]; pchn[i] = pchn[i-1]; psync[i] = psync[i-1];
      pdp1[i] = pdp1[i-1]; pdp2[i] = pdp2[i-1];
    end
    pdv[0] = 1'b0; pchn[0] = 8'(ch); psync[0] = sy;
    if (!rst && dv && ch >= NUM_CH) merr = 1'b1;
    if (!rst && dv && ch < NUM_CH) begin
      if (sy) for (int c = 0; c < NUM_CH; c++) mflush[c] = 1'b1;
      pdv[0] = 1'b1;
      for (int l = 0; l < 3; l++) begin
        w[0] = int'($signed(dq[l]));
        for (int k = 1; k < 8; k++) w[k] = mflush[ch] ? 0 : mh[ch][l][k-1];
        pdp1[0][l] = 16'(w[4]);
        pdp2[0][l] = model_dp2(w);
        for (int k = 0; k < 7; k++) mh[ch][l][k] = w[k];
      end
      mflush[ch] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) pdv[i] = 1'b0;
      for (int c = 0; c < NUM_CH; c++) mflush[c] = 1'b1;
      merr = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, i, 1'b1, {16'h1111, 16'h2222, 16'h3333});
      total++;
      if (dout_dv !== 1'b0 || sync_out !== 1'b0 || err_chn !== 1'b0 || dout_chn !== 8'd0 ||
          dout_dp1 !== 48'd0 || dout_dp2 !== 48'd0) begin
        bad++;
        $display("FAIL reset_state: got dv=%b sy=%b err=%b ch=%0d dp1=%h dp2=%h, want all zero",
                 dout_dv, sync_out, err_chn, dout_chn, dout_dp1, dout_dp2);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    int k = 0;
    logic [15:0] s;
    for (int i = 0; i < 12; i++) begin
      s = (i == 0) ? 16'h4000 : 16'h0000;
      tick(i < 8, 0, 1'b0, {16'h0000 - s, s, s});
      total++;
      if (dout_dv !== pdv[3] || (pdv[3] && (dout_chn !== pchn[3] || sync_out !== psync[3] ||
          dout_dp1 !== pdp1[3] || dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL impulse_out t%0d: got dv=%b ch=%0d dp1=%h dp2=%h, want dv=%b ch=%0d dp1=%h dp2=%h",
                 i, dout_dv, dout_chn, dout_dp1, dout_dp2, pdv[3], pchn[3], pdp1[3], pdp2[3]);
      end
      if (dout_dv === 1'b1 && k < 8) begin
        total++;
        if (dout_dp2[0] !== imp[k] || dout_dp1[0] !== ((k == 4) ? 16'h4000 : 16'h0000)) begin
          bad++;
          $display("FAIL impulse_seq k=%0d: got dp2=%0d dp1=%0d, want dp2=%0d dp1=%0d", k,
                   $signed(dout_dp2[0]), $signed(dout_dp1[0]), $signed(imp[k]), (k == 4) ? 16384 : 0);
        end
        k++;
      end
    end
    total++;
    if (k !== 8) begin bad++; $display("FAIL impulse_count: got %0d outputs, want 8", k); end
  endtask

  task automatic test_dc();
    int k = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 16, 3, 1'b0, {16'h1000, 16'h1000, 16'h1000});
      total++;
      if (dout_dv !== pdv[3] || (pdv[3] && (dout_chn !== pchn[3] || dout_dp1 !== pdp1[3] ||
          dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL dc_out t%0d: got dv=%b dp1=%h dp2=%h, want dv=%b dp1=%h dp2=%h",
                 i, dout_dv, dout_dp1, dout_dp2, pdv[3], pdp1[3], pdp2[3]);
      end
      if (dout_dv === 1'b1) begin
        if (k >= 7) begin
          total++;
          if (dout_dp1 !== {3{16'h1000}} || dout_dp2 !== {3{16'h1000}}) begin
            bad++;
            $display("FAIL dc_level k=%0d: got dp1=%h dp2=%h, want 100010001000", k, dout_dp1, dout_dp2);
          end
        end
        k++;
      end
    end
    total++;
    if (k !== 16) begin bad++; $display("FAIL dc_count: got %0d outputs, want 16", k); end
  endtask

  task automatic test_interleave();
    int k1 = 0;
    logic [15:0] s;
    for (int i = 0; i < 20; i++) begin
      s = (i == 1) ? 16'h4000 : 16'h0000;
      tick(i < 16, i % 2, 1'b0, {s, s, s});
      total++;
      if (dout_dv !== pdv[3] || (pdv[3] && (dout_chn !== pchn[3] || dout_dp1 !== pdp1[3] ||
          dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL interleave_out t%0d: got dv=%b ch=%0d dp2=%h, want dv=%b ch=%0d dp2=%h",
                 i, dout_dv, dout_chn, dout_dp2, pdv[3], pchn[3], pdp2[3]);
      end
      if (dout_dv === 1'b1 && dout_chn === 8'd0) begin
        total++;
        if (dout_dp1 !== 48'd0 || dout_dp2 !== 48'd0) begin
          bad++;
          $display("FAIL interleave_ch0: got dp1=%h dp2=%h, want 0", dout_dp1, dout_dp2);
        end
      end
      if (dout_dv === 1'b1 && dout_chn === 8'd1 && k1 < 8) begin
        total++;
        if (dout_dp2[0] !== imp[k1]) begin
          bad++;
          $display("FAIL interleave_ch1 k=%0d: got %0d, want %0d", k1, $signed(dout_dp2[0]), $signed(imp[k1]));
        end
        k1++;
      end
    end
  endtask

  task automatic test_flush();
    int n2 = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8)       tick(1'b1, 2, 1'b0, {3{16'h2000}});
      else if (i == 8) tick(1'b1, 5, 1'b1, {3{16'h0123}});
      else             tick(i == 9, 2, 1'b0, 48'd0);
      total++;
      if (dout_dv !== pdv[3] || (pdv[3] && (dout_chn !== pchn[3] || sync_out !== psync[3] ||
          dout_dp1 !== pdp1[3] || dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL flush_out t%0d: got dv=%b ch=%0d sy=%b dp1=%h dp2=%h, want dv=%b ch=%0d sy=%b dp1=%h dp2=%h",
                 i, dout_dv, dout_chn, sync_out, dout_dp1, dout_dp2, pdv[3], pchn[3], psync[3], pdp1[3], pdp2[3]);
      end
      if (dout_dv === 1'b1 && dout_chn === 8'd2) begin
        n2++;
        if (n2 == 9) begin
          total++;
          if (dout_dp1 !== 48'd0 || dout_dp2 !== 48'd0) begin
            bad++;
            $display("FAIL flush_zero: got dp1=%h dp2=%h, want 0", dout_dp1, dout_dp2);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    int n_hi = 0;
    int n_lo = 0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 16, 0, 1'b0, {3{((i % 4) < 2) ? 16'h7fff : 16'h8000}});
      total++;
      if (dout_dv !== pdv[3] || (pdv[3] && (dout_dp1 !== pdp1[3] || dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL overflow_out t%0d: got dv=%b dp2=%h, want dv=%b dp2=%h", i, dout_dv, dout_dp2, pdv[3], pdp2[3]);
      end
      if (dout_dv === 1'b1 && dout_dp2[0] === 16'h7fff) n_hi++;
      if (dout_dv === 1'b1 && dout_dp2[0] === 16'h8000) n_lo++;
    end
    total++;
`ifdef PRACH_HB1_INT_SAT_EN
    if (n_hi == 0 || n_lo == 0) begin
      bad++;
      $display("FAIL overflow_clamp: got hi=%0d lo=%0d clamps, want both nonzero", n_hi, n_lo);
    end
`else
    if (n_hi != 0 || n_lo != 0) begin
      bad++;
      $display("FAIL overflow_wrap: got hi=%0d lo=%0d clamps, want none", n_hi, n_lo);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, NUM_CH), $urandom_range(0, 19) == 0,
           48'({$urandom, $urandom}));
      total++;
      if (dout_dv !== pdv[3] || err_chn !== merr || (pdv[3] && (dout_chn !== pchn[3] ||
          sync_out !== psync[3] || dout_dp1 !== pdp1[3] || dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL random_out t%0d: got dv=%b err=%b ch=%0d sy=%b dp1=%h dp2=%h, want dv=%b err=%b ch=%0d sy=%b dp1=%h dp2=%h",
                 i, dout_dv, err_chn, dout_chn, sync_out, dout_dp1, dout_dp2,
                 pdv[3], merr, pchn[3], psync[3], pdp1[3], pdp2[3]);
      end
    end
  endtask

  task automatic test_bad_channel();
    test_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      tick(1'b1, 0, 1'b0, {16'h0800, 16'hf000, 16'h1234});
      else if (i == 1) tick(1'b1, NUM_CH, 1'b0, {3{16'h5555}});
      else             tick(i < 5, 0, 1'b0, 48'd0);
      total++;
      if (dout_dv !== pdv[3] || err_chn !== (i >= 1) || (pdv[3] && (dout_chn !== pchn[3] ||
          dout_dp1 !== pdp1[3] || dout_dp2 !== pdp2[3]))) begin
        bad++;
        $display("FAIL bad_channel t%0d: got dv=%b err=%b dp2=%h, want dv=%b err=%b dp2=%h",
                 i, dout_dv, err_chn, dout_dp2, pdv[3], (i >= 1), pdp2[3]);
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b1, i, 1'b0, {3{16'h0321}});
    rst = 1'b1;
    tick(1'b1, 4, 1'b0, {3{16'h0321}});
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 0, 1'b0, 48'd0);
      total++;
      if (dout_dv !== 1'b0 || err_chn !== 1'b0) begin
        bad++;
        $display("FAIL reset_midstream t%0d: got dv=%b err=%b, want dv=0 err=0", i, dout_dv, err_chn);
      end
    end
  endtask

  initial begin
    rst = 1'b1; din_dv = 1'b0; din_chn = 8'd0; sync_in = 1'b0; din_dq = 48'd0; merr = 1'b0;
    imp = '{-16'sd192, 16'sd880, -16'sd2504, 16'sd10008, 16'sd10008, -16'sd2504, 16'sd880, -16'sd192};
    for (int i = 0; i < 4; i++) pdv[i] = 1'b0;
    test_reset();
    test_impulse();
    test_dc();
    test_interleave();
    test_flush();
    test_overflow();
    test_random();
    test_bad_channel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prach_hb1_int.md
PRACH_HB1_INT -- requirements
Module: prach_hb1_int

Interface
REQ-001 Parameter NUM_CH, default 8: number of TDM channels, valid din_chn range 0..NUM_CH-1.
REQ-002 Parameters C0..C3, 18-bit signed Q2.16, defaults -768, 3520, -10016, 40032: unique odd-phase coefficients.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 din_dq  in  16 x 3  one sample per lane, signed Q1.15, lanes fully parallel.
REQ-006 din_dv  in  1  input sample valid.
REQ-007 din_chn  in  8  channel index of the input sample.
REQ-008 sync_in  in  1  frame restart, sampled only when din_dv=1.
REQ-009 dout_dp1  out  16 x 3  even phase (delayed centre sample).
REQ-010 dout_dp2  out  16 x 3  odd phase (filtered sample).
REQ-011 dout_dv, dout_chn (8), sync_out  out  output valid, channel, and sync, aligned to dout_dp1/dout_dp2.
REQ-012 err_chn  out  1  sticky flag: out-of-range channel seen.

Function
REQ-013 The block SHALL be the 2x half-band interpolator feeding the half-band decimator: each valid input yields one dp1/dp2 pair, two phases in one cycle.
REQ-014 Per lane and per channel, history SHALL hold the previous 7 accepted samples x[n-1]..x[n-7], stored in channel-indexed memory (depth NUM_CH).
REQ-015 dout_dp1 SHALL equal x[n-4], unscaled.
REQ-016 dout_dp2 SHALL equal (C0*(x[n]+x[n-7]) + C1*(x[n-1]+x[n-6]) + C2*(x[n-2]+x[n-5]) + C3*(x[n-3]+x[n-4]) + 2^15) >>> 16.
REQ-017 Pre-adds SHALL be 17 bits, products 35 bits, accumulator 37 bits, with no intermediate truncation.
REQ-018 Latency SHALL be exactly 4 cycles from a din_dv=1 cycle to its dout_dv=1 cycle; dout_chn and sync_out SHALL be that input's din_chn and sync_in.
REQ-019 When din_dv=0, history SHALL be unchanged and no output SHALL be produced; back-to-back valids on any channel order, including the same channel on consecutive cycles, SHALL be supported.
REQ-020 Same-channel back-to-back SHALL use forwarding so that the second sample sees the first in its history.
REQ-021 sync_in=1 with din_dv=1 SHALL set a per-channel pending-flush flag for every channel.
REQ-022 The current sample SHALL be processed with a zero history and SHALL clear its own flag.
REQ-023 Each other channel's next accepted sample SHALL use a zero history and clear that channel's flag.
REQ-024 din_chn >= NUM_CH with din_dv=1 SHALL drop the sample, produce no output, leave history untouched, and set err_chn.

Reset
REQ-025 While rst=1, dout_dv, sync_out, and err_chn SHALL be 0, and dout_dp1, dout_dp2, and dout_chn SHALL be 0.
REQ-026 Reset SHALL set every pending-flush flag, so the first sample per channel after reset sees a zero history; history memory itself is not cleared.
REQ-027 Reset asserted mid-pipeline SHALL discard all in-flight samples; no dout_dv SHALL appear for inputs accepted up to 4 cycles before the reset.

Configuration
REQ-028 With PRACH_HB1_INT_SAT_EN defined, dout_dp2 SHALL saturate to +32767/-32768 on overflow.
REQ-029 Without PRACH_HB1_INT_SAT_EN, dout_dp2 SHALL be the low 16 bits of the rounded result (two's-complement wrap); dout_dp1 is never affected.

Verification
REQ-030 Impulse test: ch0, 0x4000 then seven zeros on consecutive valids, after reset -> dp2 = -192, 880, -2504, 10008, 10008, -2504, 880, -192, and dp1 = 16384 only on the 5th output.
REQ-031 DC test: 0x1000 held on ch3 for 16 valids -> from the 8th output onward, dp1 = dp2 = 0x1000 on all lanes.
REQ-032 Interleaving test: ch0/ch1/ch0/ch1 back-to-back with impulses on ch1 only -> ch0 outputs all 0, ch1 shows the impulse sequence, and outputs arrive 4 cycles after each input.
REQ-033 Flush test: ch2 at DC 0x2000, sync_in on a ch5 sample, then a ch2 sample of 0 -> that ch2 output has dp2 = 0 and dp1 = 0.
REQ-034 Overflow test: ch0 alternating pattern +32767,+32767,-32768,-32768,... -> dp2 clamps at +32767/-32768 with the macro defined, and wraps without it.
REQ-035 Bad-channel test: din_chn=NUM_CH with din_dv=1 -> no dout_dv and err_chn=1 until rst; rst mid-stream -> dout_dv=0 for the next 4 cycles.
